// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3x3 filter front end: line-buffer clear/advance, row/col tracking, window-valid output.
// Optional build macro LB_CTRL_SOF_RESYNC_EN: a mid-frame SOF restarts the frame instead of being absorbed.
module line_buffer_ctrl #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_sof,
    output logic                        lb_reset,
    output logic                        lb_enable,
    output logic [DATA_WIDTH-1:0]       lb_pixel,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(HEIGHT)-1:0]   m_row,
    output logic [$clog2(WIDTH)-1:0]    m_col,
    output logic                        frame_done,
    output logic                        sof_err
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, CLEAR, PRIME, RUN, DONE} state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          err_q;

    logic active;
    logic at_origin;
    logic last_col;
    logic win_hit;
    logic out_free;
    logic mid_sof;
    logic resync_hit;
    logic err_hit;

    assign active    = (state == PRIME) || (state == RUN);
    assign at_origin = (row == '0) && (col == '0);
    assign last_col  = (col == CW'(WIDTH - 1));
    assign win_hit   = (row >= RW'(2)) && (col >= CW'(2));
    assign out_free  = !m_valid || m_ready;
    assign mid_sof   = active && s_valid && s_sof && !at_origin;

`ifdef LB_CTRL_SOF_RESYNC_EN
    // The offending SOF pixel is refused here and re-accepted as (0,0) after CLEAR.
    assign s_ready    = (state == IDLE) ? !s_sof
                                        : active && out_free && !(s_sof && !at_origin);
    assign resync_hit = mid_sof;
    assign err_hit    = 1'b0;
`else
    assign s_ready    = (state == IDLE) ? !s_sof : active && out_free;
    assign resync_hit = 1'b0;
    assign err_hit    = mid_sof && lb_enable;
`endif

    assign lb_enable  = active && s_valid && s_ready;
    assign lb_pixel   = s_data;
    assign lb_reset   = (state == CLEAR);
    assign frame_done = (state == DONE);
    assign sof_err    = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            m_valid <= 1'b0;
            m_row   <= '0;
            m_col   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;

            // A fresh window load takes priority over the downstream handshake.
            if (lb_enable && win_hit) begin
                m_valid <= 1'b1;
                m_row   <= row - RW'(1);
                m_col   <= col - CW'(1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (lb_enable) begin
                if (last_col) begin
                    col <= '0;
                    row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (s_valid && s_sof) state <= CLEAR;
                end
                CLEAR: begin
                    row   <= '0;
                    col   <= '0;
                    state <= PRIME;
                end
                PRIME, RUN: begin
                    if (resync_hit) begin
                        err_q <= 1'b1;
                        state <= CLEAR;
                    end else begin
                        if (err_hit) err_q <= 1'b1;
                        if (lb_enable && last_col) begin
                            if (state == PRIME && row == RW'(1))
                                state <= RUN;
                            else if (state == RUN && row == RW'(HEIGHT - 1))
                                state <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized bench for line_buffer_ctrl (4x4 frame): pixel-position scoreboard, handshake and pulse-timing checks.
module tb_line_buffer_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
`ifdef LB_CTRL_SOF_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, s_valid, s_ready, s_sof;
    logic [DW-1:0] s_data, lb_pixel;
    logic          lb_reset, lb_enable, m_valid, m_ready, frame_done, sof_err;
    logic [1:0]    m_row, m_col;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .lb_reset(lb_reset), .lb_enable(lb_enable), .lb_pixel(lb_pixel),
        .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .m_col(m_col),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    int cyc = 0;
    int exp_r[$];
    int exp_c[$];
    int win_cnt = 0, lbr_cnt = 0, lbr_cyc = -10, fd_cnt = 0, fd_cyc = 0, err_cnt = 0, en_cnt = 0;
    int last_acc = 0;
    bit in_frame = 0, hold_v = 0, rnd_rdy = 0, bp_req = 0;
    int hold_r, hold_c;

    always @(posedge clk) cyc++;

    // Downstream ready: steady, random, or a 5-cycle stall at the first window
    initial begin
        int stall = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_req && m_valid) begin bp_req = 0; stall = 5; end
            if (stall > 0) begin m_ready = 1'b0; stall--; end
            else m_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (lb_reset) begin lbr_cnt++; lbr_cyc = cyc; end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (sof_err) err_cnt++;
            if (lb_enable) en_cnt++;
            chk("lb_pixel", lb_pixel, s_data);
            chk("lb_en_hs", lb_enable & ~(s_valid & s_ready), 0);
            if (in_frame && m_valid && !m_ready) chk("bp_s_ready", s_ready, 0);
            if (hold_v) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_row", m_row, hold_r);
                chk("hold_col", m_col, hold_c);
            end
            hold_v = m_valid && !m_ready;
            hold_r = m_row;
            hold_c = m_col;
            if (m_valid && m_ready) begin
                win_cnt++;
                chk("win_expected", exp_r.size() > 0, 1);
                if (exp_r.size() > 0) begin
                    chk("win_row", m_row, exp_r.pop_front());
                    chk("win_col", m_col, exp_c.pop_front());
                end
            end
        end
    end

    // Present one pixel at frame position pos and hold it until accepted
    task automatic send_item(input bit sof, input int pos, output bit ok);
        int  n = 0;
        bit  acc;
        bit  win;
        win = (pos / W >= 2) && (pos % W >= 2);
        if (!sof && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0; @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = DW'($urandom);
        ok = 0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) begin
                chk("lb_en_acc", lb_enable, 1);
                if (pos == 0 && !rnd_rdy) chk("lb_reset_lead", cyc - lbr_cyc, 1);
                if (win) begin exp_r.push_back(pos / W - 1); exp_c.push_back(pos % W - 1); end
                last_acc = cyc;
            end
            @(posedge clk); #1;
            if (acc) begin
                ok = 1;
                if (win) begin
                    chk("lat_valid", m_valid, 1);
                    chk("lat_row", m_row, pos / W - 1);
                    chk("lat_col", m_col, pos % W - 1);
                end
            end
            n++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    // One frame; sof_at >= 0 injects a mid-frame SOF at that pixel; stop_at > 0 abandons after that many accepts
    task automatic run_frame(input int sof_at, input int stop_at, input bit bp);
        int lbr0 = lbr_cnt, fd0 = fd_cnt, err0 = err_cnt, win0 = win_cnt, en0 = en_cnt;
        int nacc = 0, nwin = 0;
        int pos_q[$];
        bit sof_q[$];
        bit ok;
        if (sof_at >= 0 && RESYNC)
            for (int p = 0; p < sof_at; p++) begin pos_q.push_back(p); sof_q.push_back(p == 0); end
        for (int p = 0; p < W * H; p++) begin
            pos_q.push_back(p);
            sof_q.push_back(p == 0 || (!RESYNC && p == sof_at));
        end
        foreach (pos_q[i]) if (pos_q[i] / W >= 2 && pos_q[i] % W >= 2) nwin++;
        bp_req = bp;
        foreach (pos_q[i]) begin
            send_item(sof_q[i], pos_q[i], ok);
            if (ok) nacc++;
            if (i == 0) in_frame = 1;
            if (stop_at > 0 && nacc >= stop_at) begin in_frame = 0; return; end
        end
        in_frame = 0;
        for (int k = 0; k < 100 && (exp_r.size() > 0 || m_valid); k++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", exp_r.size(), 0);
        chk("windows", win_cnt - win0, nwin);
        chk("frame_done_cnt", fd_cnt - fd0, 1);
        chk("frame_done_cyc", fd_cyc - last_acc, 1);
        chk("lb_reset_cnt", lbr_cnt - lbr0, (sof_at >= 0 && RESYNC) ? 2 : 1);
        chk("sof_err_cnt", err_cnt - err0, (sof_at >= 0) ? 1 : 0);
        chk("lb_en_cnt", en_cnt - en0, nacc);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lb_reset", lb_reset, 0);
        chk("rst_lb_enable", lb_enable, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_row", m_row, 0);
        chk("rst_m_col", m_col, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-SOF pixels in IDLE are consumed but never written
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = DW'($urandom);
            @(negedge clk);
            chk("idle_lb_en", lb_enable, 0);
            chk("idle_s_ready", s_ready, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_frame(-1, 0, 0);
        run_frame(-1, 0, 1);
        run_frame(7, 0, 0);

        // Reset during row 2
        run_frame(-1, 10, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_lb_reset", lb_reset, 0);
        chk("mrst_frame_done", frame_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_r.delete(); exp_c.delete();
        s_valid = 1'b1; s_sof = 1'b0;
        @(negedge clk);
        chk("mrst_idle_lb_en", lb_enable, 0);
        chk("mrst_idle_s_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        run_frame(-1, 0, 0);

        rnd_rdy = 1;
        for (int f = 0; f < 8; f++)
            run_frame(($urandom_range(0, 2) == 0) ? $urandom_range(1, W * H - 1) : -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
